// File: rtl/store_unit_pkg.sv
// store_unit_pkg
//   Shared types for the store unit: access-size encoding (same values as the
//   CPU-wide BYTE/HALF_WORD/WORD/DOUBLE_WORD constants), buffered store entry,
//   and the row-write FSM state encoding.
package store_unit_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    BYTE        = 2'd0,
    HALF_WORD   = 2'd1,
    WORD        = 2'd2,
    DOUBLE_WORD = 2'd3
  } st_size_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    st_size_e          size;
  } st_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } st_state_e;

endpackage

// File: rtl/store_unit_if.sv
// store_req_if : execute -> store unit request channel.
//   st_valid   request valid (master)
//   st_ready   store buffer can accept (slave)
//   st_addr    byte address
//   st_data    LSB-justified store data
//   st_byte_en access size (st_size_e encoding)
// mem_wr_if    : store unit -> data memory row-write channel.
//   mem_wr_valid / mem_wr_ready handshake, row address, row data, byte strobes.
interface store_req_if;
  import store_unit_pkg::*;

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [1:0]        st_byte_en;

  modport master (output st_valid, st_addr, st_data, st_byte_en, input st_ready);
  modport slave  (input st_valid, st_addr, st_data, st_byte_en, output st_ready);
endinterface

interface mem_wr_if;
  import store_unit_pkg::*;

  logic              mem_wr_valid;
  logic              mem_wr_ready;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [STRB_W-1:0] mem_wr_strb;

  modport master (output mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb,
                  input mem_wr_ready);
  modport slave  (input mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb,
                  output mem_wr_ready);
endinterface

// File: rtl/store_unit_align.sv
// store_align
//   Combinational alignment of one store onto a 16-byte window (two rows).
//   Ports:
//     i_size     access size
//     i_off      byte offset within the row (addr[2:0])
//     i_data     LSB-justified store data
//     o_strb16   byte strobes, low byte = byte 0 of first row
//     o_data128  aligned data, bytes outside the strobe forced to 0
module store_align
  import store_unit_pkg::*;
(
  input  st_size_e              i_size,
  input  logic [2:0]            i_off,
  input  logic [DATA_W-1:0]     i_data,
  output logic [2*STRB_W-1:0]   o_strb16,
  output logic [2*DATA_W-1:0]   o_data128
);

  logic [2*STRB_W-1:0] w_lanes;
  logic [DATA_W-1:0]   w_data_m;

  // Upper bits beyond the access size are cleared so unstrobed bytes read 0.
  always_comb begin
    w_lanes  = '0;
    w_data_m = '0;
    case (i_size)
      BYTE: begin
        w_lanes  = 16'h0001;
        w_data_m = {56'b0, i_data[7:0]};
      end
      HALF_WORD: begin
        w_lanes  = 16'h0003;
        w_data_m = {48'b0, i_data[15:0]};
      end
      WORD: begin
        w_lanes  = 16'h000F;
        w_data_m = {32'b0, i_data[31:0]};
      end
      DOUBLE_WORD: begin
        w_lanes  = 16'h00FF;
        w_data_m = i_data;
      end
      default: begin
        w_lanes  = '0;
        w_data_m = '0;
      end
    endcase
  end

  assign o_strb16  = w_lanes << i_off;
  assign o_data128 = {64'b0, w_data_m} << {i_off, 3'b000};

endmodule

// File: rtl/store_unit.sv
// store_unit
//   Buffers stores from execute in an in-order FIFO and issues them to data
//   memory as 8-byte row writes with byte strobes. A store that crosses a row
//   boundary is issued as two beats (LO row, then HI row) before it is popped.
//   Ports:
//     clk_i, resetn_i  clock, synchronous active-low reset
//     st               store request channel (slave)
//     mem              row write channel (master)
//     buf_empty_o      nothing buffered and no beat in flight
//     buf_count_o      entries held (head stays counted until fully written)
//
//   state | meaning
//   IDLE  | no beat presented; loads head into LO when FIFO non-empty
//   LO    | presenting first (or only) row of the head entry
//   HI    | presenting second row of a row-crossing head entry
module store_unit
  import store_unit_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  store_req_if.slave                 st,
  mem_wr_if.master                   mem,
  output logic                       buf_empty_o,
  output logic [$clog2(BUF_DEPTH):0] buf_count_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  st_entry_t r_mem [BUF_DEPTH];
  ptr_t      r_wr_ptr;
  ptr_t      r_rd_ptr;
  cnt_t      r_count;

  st_state_e         r_state;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [STRB_W-1:0] r_strb;
  // Second row of the current head, captured when its LO beat is loaded.
  logic [ADDR_W-1:0] r_hi_addr;
  logic [DATA_W-1:0] r_hi_data;
  logic [STRB_W-1:0] r_hi_strb;

  logic                w_full;
  logic                w_push;
  logic                w_beat_done;
  logic                w_pop;
  logic                w_more;
  ptr_t                w_load_ptr;
  st_entry_t           w_load;
  logic [ADDR_W-1:0]   w_row;
  logic [2*STRB_W-1:0] w_strb16;
  logic [2*DATA_W-1:0] w_data128;

  assign w_full      = (r_count == cnt_t'(BUF_DEPTH));
  assign w_push      = st.st_valid && !w_full;
  assign w_beat_done = r_valid && mem.mem_wr_ready;
  // A beat retires the entry when it is the HI row or the LO row had no HI part.
  assign w_pop       = w_beat_done && ((r_state == HI) || (r_hi_strb == '0));
  // Entries other than the head; one enqueued this cycle is not yet readable.
  assign w_more      = (r_count > cnt_t'(1));

  // The entry to load next is the head, or the one behind it when popping.
  assign w_load_ptr  = w_pop ? ptr_t'(r_rd_ptr + 1'b1) : r_rd_ptr;
  assign w_load      = r_mem[w_load_ptr];
  assign w_row       = {w_load.addr[ADDR_W-1:3], 3'b000};

  store_align u_align (
    .i_size    (w_load.size),
    .i_off     (w_load.addr[2:0]),
    .i_data    (w_load.data),
    .o_strb16  (w_strb16),
    .o_data128 (w_data128)
  );

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{addr: st.st_addr, data: st.st_data,
                           size: st_size_e'(st.st_byte_en)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_strb    <= '0;
      r_hi_addr <= '0;
      r_hi_data <= '0;
      r_hi_strb <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_count != '0) begin
            r_state   <= LO;
            r_valid   <= 1'b1;
            r_addr    <= w_row;
            r_data    <= w_data128[DATA_W-1:0];
            r_strb    <= w_strb16[STRB_W-1:0];
            r_hi_addr <= w_row + 64'd8;
            r_hi_data <= w_data128[2*DATA_W-1:DATA_W];
            r_hi_strb <= w_strb16[2*STRB_W-1:STRB_W];
          end
        end
        LO, HI: begin
          if (w_beat_done) begin
            if (!w_pop) begin
              r_state <= HI;
              r_addr  <= r_hi_addr;
              r_data  <= r_hi_data;
              r_strb  <= r_hi_strb;
            end else if (w_more) begin
              r_state   <= LO;
              r_addr    <= w_row;
              r_data    <= w_data128[DATA_W-1:0];
              r_strb    <= w_strb16[STRB_W-1:0];
              r_hi_addr <= w_row + 64'd8;
              r_hi_data <= w_data128[2*DATA_W-1:DATA_W];
              r_hi_strb <= w_strb16[2*STRB_W-1:STRB_W];
            end else begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_addr  <= '0;
              r_data  <= '0;
              r_strb  <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign st.st_ready      = !w_full;
  assign mem.mem_wr_valid = r_valid;
  assign mem.mem_wr_addr  = r_addr;
  assign mem.mem_wr_data  = r_data;
  assign mem.mem_wr_strb  = r_strb;
  assign buf_empty_o      = (r_count == '0) && (r_state == IDLE);
  assign buf_count_o      = r_count;

endmodule
